// File: rtl/demux_1in_4out_seq.sv
// demux_1in_4out_seq
//   Registered 1:4 stream demultiplexer with valid/ready handshakes. Each input
//   word goes to one of four single-entry output registers, picked either by
//   in_sel (directed mode) or by a round-robin pointer (sequence mode).
//   Optional feature macro: DEMUX_CNT_EN adds cnt_clr/cnt, which hold one
//   delivered-word counter per channel.
module demux_1in_4out_seq #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef DEMUX_CNT_EN
    input  logic                cnt_clr,
    output logic [4*CNT_W-1:0]  cnt,
`endif
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                seq_mode,
    output logic [4*DATA_W-1:0] out_data,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] tgt;
    logic       accept;

    // The target is combinational, so a mode change takes effect in the same cycle.
    assign tgt      = seq_mode ? ptr_q : in_sel;
    // A channel can take a word if it is empty or is being emptied this cycle.
    assign in_ready = ~out_valid[tgt] | out_ready[tgt];
    assign accept   = in_valid & in_ready;

    // The round-robin pointer advances only on sequence-mode accepts and never skips a busy channel.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && seq_mode) begin
            ptr_d = ptr_q + 2'd1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic              load;
            logic              drain;
            logic              valid_q;
            logic              valid_d;
            logic [DATA_W-1:0] data_q;
            logic [DATA_W-1:0] data_d;

            assign load  = accept & (tgt == 2'(gi));
            assign drain = valid_q & out_ready[gi];

            // A load wins over a drain, which keeps one word per clock flowing through a channel.
            // The data stays put after a drain so consumers see a stable bus.
            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (load) begin
                    valid_d = 1'b1;
                    data_d  = in_data;
                end else if (drain) begin
                    valid_d = 1'b0;
                end
            end

            // Output holding register for this channel.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign out_valid[gi]                   = valid_q;
            assign out_data[gi*DATA_W +: DATA_W]   = data_q;

`ifdef DEMUX_CNT_EN
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Count each delivered word; wrapping is natural. A clear beats an increment.
            always_comb begin
                cnt_d = cnt_q;
                if (cnt_clr) begin
                    cnt_d = '0;
                end else if (drain) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Delivered-word counter register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt[gi*CNT_W +: CNT_W] = cnt_q;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_demux_1in_4out_seq.sv
// tb_demux_1in_4out_seq
//   Scoreboard bench for demux_1in_4out_seq. Each channel is modelled as a queue
//   of words that are still owed to its consumer. A predictor pushes the words
//   the block must accept, and a monitor pops them when the consumer takes a word.
//   Inputs change 1 ns after the rising edge. Outputs are sampled on the falling edge.
module tb_demux_1in_4out_seq;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [DATA_W-1:0]   in_data;
    logic [1:0]          in_sel;
    logic                in_valid;
    logic                in_ready;
    logic                seq_mode;
    logic [4*DATA_W-1:0] out_data;
    logic [3:0]          out_valid;
    logic [3:0]          out_ready;
`ifdef DEMUX_CNT_EN
    logic                cnt_clr;
    logic [4*CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]    cnt_m [4];
`endif

    always #5 clk = ~clk;

    demux_1in_4out_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DEMUX_CNT_EN
        .cnt_clr   (cnt_clr),
        .cnt       (cnt),
`endif
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seq_mode  (seq_mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Reference model: owed words per channel, last delivered word, and the round-robin position.
    logic [DATA_W-1:0] exp_q [4][$];
    logic [DATA_W-1:0] held  [4];
    logic [1:0]        mptr;
    int                checks = 0;
    int                errors = 0;

    logic [DATA_W-1:0] mon_exp;
    logic [1:0]        pred_t;
    logic              pred_rdy;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            held[i] = '0;
`ifdef DEMUX_CNT_EN
            cnt_m[i] = '0;
`endif
        end
        mptr = 2'd0;
    endtask

    // Monitor: compare channel state to the model and retire the words that consumers take.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (exp_q[i].size() != 0) mon_exp = exp_q[i][0];
                else                      mon_exp = held[i];
                chk($sformatf("valid_ch%0d", i), 64'(out_valid[i]), 64'(exp_q[i].size() != 0));
                chk($sformatf("data_ch%0d", i), 64'(out_data[i*DATA_W +: DATA_W]), 64'(mon_exp));
`ifdef DEMUX_CNT_EN
                chk($sformatf("cnt_ch%0d", i), 64'(cnt[i*CNT_W +: CNT_W]), 64'(cnt_m[i]));
`endif
                if (exp_q[i].size() != 0 && out_ready[i]) begin
                    held[i] = exp_q[i].pop_front();
                    $display("deliver ch%0d data=%02h", i, held[i]);
`ifdef DEMUX_CNT_EN
                    cnt_m[i] = cnt_m[i] + 1'b1;
`endif
                end
            end
`ifdef DEMUX_CNT_EN
            if (cnt_clr) begin
                for (int i = 0; i < 4; i++) cnt_m[i] = '0;
            end
`endif
        end
    end

    // Predictor: this runs after the monitor's pops. The target can accept only if nothing is still owed on it.
    always @(negedge clk) begin
        if (rst_n) begin
            #2;
            pred_t   = seq_mode ? mptr : in_sel;
            pred_rdy = (exp_q[pred_t].size() == 0);
            chk("in_ready", 64'(in_ready), 64'(pred_rdy));
            if (in_valid && pred_rdy) begin
                exp_q[pred_t].push_back(in_data);
                if (seq_mode) mptr = mptr + 2'd1;
            end
        end
    end

    task automatic drv(input logic v, input logic [7:0] d, input logic [1:0] s,
                       input logic m, input logic [3:0] r);
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        seq_mode  = m;
        out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [7:0] d, input logic [1:0] s,
                        input logic m, input logic [3:0] r);
        drv(v, d, s, m, r);
        step();
    endtask

    logic [7:0] t1_data [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        model_reset();
        drv(1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
`ifdef DEMUX_CNT_EN
        cnt_clr = 1'b0;
`endif
        rst_n = 1'b0;
        step();
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_data", 64'(out_data), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        step();
        rst_n = 1'b1;

        // Directed words sent back to back to every channel
        for (int i = 0; i < 4; i++) send(1'b1, t1_data[i], 2'(i), 1'b0, 4'hF);
        send(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        send(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

        // Backpressure on channel 2
        send(1'b1, 8'h11, 2'd2, 1'b0, 4'b1011);
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 8'h22, 2'd2, 1'b0, 4'b1011);
            #1 chk("bp_stall", 64'(in_ready), 64'h0);
            step();
        end
        drv(1'b1, 8'h22, 2'd2, 1'b0, 4'hF);
        #1 chk("bp_release", 64'(in_ready), 64'h1);
        step();
        send(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        send(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

        // Sequence mode goes through channels 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) send(1'b1, 8'(i), 2'd3, 1'b1, 4'hF);
        send(1'b0, 8'h00, 2'd0, 1'b1, 4'hF);

        // Stall in sequence mode: move the pointer to 1 with channel 1 still full
        for (int i = 0; i < 3; i++) send(1'b1, 8'h30 + 8'(i), 2'd0, 1'b1, 4'hF);
        send(1'b1, 8'h40, 2'd0, 1'b1, 4'b1101);
        for (int i = 0; i < 3; i++) send(1'b1, 8'h41 + 8'(i), 2'd0, 1'b1, 4'b1101);
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 8'h44, 2'd0, 1'b1, 4'b1101);
            #1 chk("seq_stall", 64'(in_ready), 64'h0);
            step();
        end
        send(1'b1, 8'h44, 2'd0, 1'b1, 4'hF);
        send(1'b1, 8'h45, 2'd0, 1'b1, 4'hF);
        send(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        send(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

        // Reset in the middle of operation with all channels full
        for (int i = 0; i < 4; i++) send(1'b1, 8'h50 + 8'(i), 2'(i), 1'b0, 4'h0);
        send(1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'h0);
        chk("midrst_data", 64'(out_data), 64'h0);
        chk("midrst_ready", 64'(in_ready), 64'h1);
        model_reset();
        step();
        rst_n = 1'b1;
        send(1'b1, 8'h5A, 2'd3, 1'b1, 4'hF);
        send(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        send(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

        // 257 deliveries on channel 3 wrap the 8-bit count back to 1
        for (int i = 0; i < 257; i++) send(1'b1, 8'(i), 2'd3, 1'b0, 4'hF);
        send(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        send(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
`ifdef DEMUX_CNT_EN
        #1 chk("cnt3_wrap", 64'(cnt[3*CNT_W +: CNT_W]), 64'h1);
        send(1'b1, 8'h77, 2'd3, 1'b0, 4'hF);
        drv(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt_clr_prec", 64'(cnt), 64'h0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            send(($urandom % 4) != 0, 8'($urandom), 2'($urandom), ($urandom % 8) < 3,
                 4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 3; i++) send(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        chk("final_empty", 64'(out_valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
